// File: rtl/game_status_ctrl.sv
// game_status_ctrl: top-level sequencer for the snake game.
// Runs START -> PLAY -> DIE (flashing) -> END -> START, drives Game_status and
// Flash_sig into the snake controller, and keeps a 2-digit BCD score.
// Game_status is the FSM state register itself. It doubles as the state
// observation point for checkers.
`timescale 1ns/1ps
module game_status_ctrl #(
  parameter int FLASH_HALF    = 12_500_000,  // cycles per Flash_sig half-period
  parameter int FLASH_TOGGLES = 8,           // half-periods spent in DIE (even, >= 2)
  parameter int END_HOLD      = 100_000_000  // cycles spent in END
) (
  input  logic       Clk_50mhz,
  input  logic       Rst_n,
  input  logic       Key_left,
  input  logic       Key_right,
  input  logic       Key_up,
  input  logic       Key_down,
  input  logic       Hit_wall_sig,
  input  logic       Hit_body_sig,
  input  logic       Body_add_sig,
  output logic [2:0] Game_status,
  output logic       Flash_sig,
  output logic [7:0] Score_bcd
);

  // Counter widths follow each parameter. A width of at least one bit is kept
  // so that a parameter of 1 still gives a legal vector.
  localparam int HALF_W = (FLASH_HALF    > 1) ? $clog2(FLASH_HALF)    : 1;
  localparam int TOG_W  = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
  localparam int HOLD_W = (END_HOLD      > 1) ? $clog2(END_HOLD)      : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(FLASH_HALF - 1);
  localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(FLASH_TOGGLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD - 1);

  // State codes equal the Game_status encoding, so the output is the register.
  typedef enum logic [2:0] {
    ST_START = 3'b001,
    ST_PLAY  = 3'b010,
    ST_DIE   = 3'b011,
    ST_END   = 3'b100
  } state_t;

  state_t             state, state_nx;
  logic               flash, flash_nx;
  logic [7:0]         score, score_nx;
  logic [HALF_W-1:0]  half_cnt, half_cnt_nx;
  logic [TOG_W-1:0]   tog_cnt, tog_cnt_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nx;
  logic [3:0]         key_prev;
  logic               body_prev;

  logic [3:0]         keys;
  logic               key_any_rise;
  logic               body_rise;
  logic               hit;

  assign keys         = {Key_left, Key_right, Key_up, Key_down};
  assign key_any_rise = |(keys & ~key_prev);
  assign body_rise    = Body_add_sig & ~body_prev;
  assign hit          = Hit_wall_sig | Hit_body_sig;

  assign Game_status  = state;
  assign Flash_sig    = flash;
  assign Score_bcd    = score;

  // Two-digit BCD increment. 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  // Edge-detect history. Keys reset high so a key held through reset cannot
  // start a game, and Body_add resets high for the same reason.
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      key_prev  <= 4'b1111;
      body_prev <= 1'b1;
    end else begin
      key_prev  <= keys;
      body_prev <= Body_add_sig;
    end
  end

  // State, flash, score and counter registers.
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_START;
      flash    <= 1'b0;
      score    <= 8'h00;
      half_cnt <= '0;
      tog_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      flash    <= flash_nx;
      score    <= score_nx;
      half_cnt <= half_cnt_nx;
      tog_cnt  <= tog_cnt_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  // Next-state logic. Every counter defaults to zero, so a counter only holds
  // a non-zero value while its own state is active.
  always_comb begin
    state_nx    = state;
    flash_nx    = 1'b0;
    score_nx    = score;
    half_cnt_nx = '0;
    tog_cnt_nx  = '0;
    hold_cnt_nx = '0;

    case (state)
      ST_START: begin
        if (key_any_rise) begin
          state_nx = ST_PLAY;
          score_nx = 8'h00;
        end
      end

      ST_PLAY: begin
        // An apple eaten in the same cycle as a hit still scores.
        if (body_rise) begin
          score_nx = bcd_inc(score);
        end
        if (hit) begin
          state_nx = ST_DIE;
          flash_nx = 1'b1;
        end
      end

      ST_DIE: begin
        flash_nx   = flash;
        tog_cnt_nx = tog_cnt;
        if (half_cnt == HALF_LAST) begin
          half_cnt_nx = '0;
          if (tog_cnt == TOG_LAST) begin
            // The last half-period has ended. Stop blinking and move to END.
            state_nx   = ST_END;
            flash_nx   = 1'b0;
            tog_cnt_nx = '0;
          end else begin
            tog_cnt_nx = tog_cnt + 1'b1;
            flash_nx   = ~flash;
          end
        end else begin
          half_cnt_nx = half_cnt + 1'b1;
        end
      end

      ST_END: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx = ST_START;
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end

      default: begin
        // Unreachable encodings fall back to START with everything idle.
        state_nx = ST_START;
      end
    endcase
  end

endmodule

// File: tb/tb_game_status_ctrl.sv
// tb_game_status_ctrl: scoreboarded bench for game_status_ctrl using short timing
// parameters. A cycle model predicts {Game_status, Flash_sig, Score_bcd} when
// each cycle's inputs are driven. The prediction goes into exp_q and is popped
// after the clock edge to compare with the DUT outputs.
`timescale 1ns/1ps
module tb_game_status_ctrl;

  localparam int FH = 4;
  localparam int FT = 4;
  localparam int EH = 10;

  localparam logic [2:0] S_START = 3'b001;
  localparam logic [2:0] S_PLAY  = 3'b010;
  localparam logic [2:0] S_DIE   = 3'b011;
  localparam logic [2:0] S_END   = 3'b100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_left, key_right, key_up, key_down;
  logic       hit_wall, hit_body, body_add;
  logic [2:0] game_status;
  logic       flash_sig;
  logic [7:0] score_bcd;

  always #5 clk = ~clk;

  game_status_ctrl #(
    .FLASH_HALF   (FH),
    .FLASH_TOGGLES(FT),
    .END_HOLD     (EH)
  ) dut (
    .Clk_50mhz   (clk),
    .Rst_n       (rst_n),
    .Key_left    (key_left),
    .Key_right   (key_right),
    .Key_up      (key_up),
    .Key_down    (key_down),
    .Hit_wall_sig(hit_wall),
    .Hit_body_sig(hit_body),
    .Body_add_sig(body_add),
    .Game_status (game_status),
    .Flash_sig   (flash_sig),
    .Score_bcd   (score_bcd)
  );

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Elapsed-cycle model: score is a plain integer, and DIE/END progress is
  // measured as cycles since entry.
  logic [2:0] m_st;
  int         m_die, m_end, m_score;
  logic [3:0] m_kprev;
  logic       m_bprev;

  task automatic model_reset();
    m_st    = S_START;
    m_die   = 0;
    m_end   = 0;
    m_score = 0;
    m_kprev = 4'b1111;
    m_bprev = 1'b1;
  endtask

  function automatic logic [11:0] model_out();
    logic f;
    f = (m_st == S_DIE) && (((m_die / FH) % 2) == 0);
    return {m_st, f, 4'(m_score / 10), 4'(m_score % 10)};
  endfunction

  task automatic model_step();
    logic [3:0] k;
    logic       kr, br;
    k  = {key_left, key_right, key_up, key_down};
    kr = |(k & ~m_kprev);
    br = body_add & ~m_bprev;
    case (m_st)
      S_START: if (kr) begin m_st = S_PLAY; m_score = 0; end
      S_PLAY: begin
        if (br) m_score = (m_score + 1) % 100;
        if (hit_wall | hit_body) begin m_st = S_DIE; m_die = 0; end
      end
      S_DIE: begin
        m_die++;
        if (m_die == FT * FH) begin m_st = S_END; m_end = 0; end
      end
      S_END: begin
        m_end++;
        if (m_end == EH) m_st = S_START;
      end
      default: m_st = S_START;
    endcase
    m_kprev = k;
    m_bprev = body_add;
  endtask

  // ---------------- driver tasks ----------------
  // One clock with the inputs currently driven: predict, clock, compare.
  task automatic tick();
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue: empty at t=%0t", $time);
    end else begin
      check("cycle", {game_status, flash_sig, score_bcd}, exp_q.pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_body();
    body_add = 1'b1; tick(); tick();
    body_add = 1'b0; tick();
  endtask

  task automatic start_game();
    key_right = 1'b0; tick();
    key_right = 1'b1; tick();
    key_right = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    {key_left, key_right, key_down} = 3'b000;
    key_up = 1'b1;
    {hit_wall, hit_body, body_add} = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {game_status, flash_sig, score_bcd}, {S_START, 1'b0, 8'h00});

    // Test 1: key held through reset does not start a game.
    rst_n = 1'b1;
    ticks(20);
    check("held_key_no_start", {9'd0, game_status}, {9'd0, S_START});
    key_up = 1'b0; tick();
    key_up = 1'b1; tick();
    check("key_rise_play", {game_status, flash_sig, score_bcd}, {S_PLAY, 1'b0, 8'h00});
    key_up = 1'b0; tick();

    // Test 2: twelve apples, then a long level counts once.
    for (int i = 0; i < 12; i++) pulse_body();
    check("score_12", {4'd0, score_bcd}, 12'h012);
    body_add = 1'b1; ticks(5);
    body_add = 1'b0; tick();
    check("score_13_level", {4'd0, score_bcd}, 12'h013);

    // Test 4: wall hit, flash pattern, END hold, back to START.
    hit_wall = 1'b1; tick();
    hit_wall = 1'b0;
    check("die_entry", {game_status, flash_sig, score_bcd}, {S_DIE, 1'b1, 8'h13});
    ticks(FT * FH - 1);
    tick();
    check("end_entry", {game_status, flash_sig, score_bcd}, {S_END, 1'b0, 8'h13});
    ticks(EH);
    check("back_to_start", {game_status, flash_sig, score_bcd}, {S_START, 1'b0, 8'h13});

    // Test 3: 99 apples then wrap to 00.
    start_game();
    check("new_game_clear", {4'd0, score_bcd}, 12'h000);
    for (int i = 0; i < 99; i++) pulse_body();
    check("score_99", {4'd0, score_bcd}, 12'h099);
    pulse_body();
    check("score_wrap", {4'd0, score_bcd}, 12'h000);

    // Test 5: apple and body hit in one cycle, then ignored inputs in DIE/END.
    for (int i = 0; i < 5; i++) pulse_body();
    hit_body = 1'b1; body_add = 1'b1; tick();
    hit_body = 1'b0; body_add = 1'b0;
    check("add_and_hit", {game_status, flash_sig, score_bcd}, {S_DIE, 1'b1, 8'h06});
    for (int i = 0; i < FT * FH + EH - 1; i++) begin
      hit_wall = ($urandom_range(0, 2) == 0);
      {key_left, key_right, key_up, key_down} = 4'($urandom_range(0, 15));
      body_add = ($urandom_range(0, 1) == 1);
      tick();
    end
    {key_left, key_right, key_up, key_down} = 4'b0000;
    {hit_wall, body_add} = 2'b00;
    tick();
    check("ignored_in_die_end", {game_status, flash_sig, score_bcd}, {S_START, 1'b0, 8'h06});

    // Test 6: asynchronous reset in the middle of DIE.
    ticks(2);
    start_game();
    for (int i = 0; i < 3; i++) pulse_body();
    hit_wall = 1'b1; tick();
    hit_wall = 1'b0;
    ticks(7);
    check("mid_die", {9'd0, game_status}, {9'd0, S_DIE});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {game_status, flash_sig, score_bcd}, {S_START, 1'b0, 8'h00});
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    ticks(4);
    start_game();
    check("restart_after_reset", {game_status, flash_sig, score_bcd}, {S_PLAY, 1'b0, 8'h00});

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_status_ctrl.md
Name: game_status_ctrl

Overview:
- Top-level game sequencer for the snake game. Sits directly upstream of Snake_ctrl_module and drives its Game_status and Flash_sig inputs.
- Consumes that module's Hit_wall_sig and Hit_body_sig outputs, plus the apple-eaten pulse Body_add_sig.
- Runs START -> PLAY -> DIE (flashing) -> END -> START.
- Maintains a 2-digit BCD score for the display stage.

Parameters:
FLASH_HALF, 12_500_000, cycles per Flash_sig half-period (0.25 s at 50 MHz)
FLASH_TOGGLES, 8, number of Flash_sig half-periods in DIE; must be even and >= 2
END_HOLD, 100_000_000, cycles spent in END before automatic return to START (2 s)

Ports:
Clk_50mhz  input  1  system clock, 50 MHz
Rst_n  input  1  asynchronous active-low reset
Key_left  input  1  debounced key, active high
Key_right  input  1  debounced key, active high
Key_up  input  1  debounced key, active high
Key_down  input  1  debounced key, active high
Hit_wall_sig  input  1  level, head hit wall (from Snake_ctrl_module)
Hit_body_sig  input  1  level, head hit body (from Snake_ctrl_module)
Body_add_sig  input  1  apple eaten; counted on rising edge
Game_status  output  3  encoding: START=3'b001, PLAY=3'b010, DIE=3'b011, END=3'b100
Flash_sig  output  1  blink enable for the snake during DIE
Score_bcd  output  8  [7:4] tens digit, [3:0] units digit, BCD

Behaviour:
- Reset: all flops clear asynchronously on Rst_n low.
  - Reset values: Game_status=START, Flash_sig=0, Score_bcd=8'h00, all counters 0.
  - Key-history register resets to 4'b1111, so a key held through reset does not start a game.
  - Body_add history register resets to 1.
- Key press: key_any_rise = OR over the four keys of (key & ~key_prev). key_prev is registered every cycle.
- Outputs: all are registered. A state change is visible in the cycle after the triggering input is sampled.
- START:
  - key_any_rise -> PLAY.
  - Score_bcd clears to 00 on this same transition edge.
  - Hit signals and Body_add_sig are ignored.
- PLAY:
  - (Hit_wall_sig | Hit_body_sig) sampled high -> DIE.
  - On DIE entry: Flash_sig=1, half-period counter=0, toggle counter=0.
  - Keys are ignored by this block.
- Score:
  - Increments on a Body_add_sig rising edge only while in PLAY.
  - Units digit 9 -> 0 with carry into tens. 99 -> 00 (wrap, no saturation).
  - Body_add rise and hit in the same cycle: the score increments and the state moves to DIE.
- DIE:
  - Half-period counter runs 0..FLASH_HALF-1. At terminal count: counter -> 0, toggle counter +1, Flash_sig inverts.
  - At the terminal count where toggle counter == FLASH_TOGGLES-1: go to END with Flash_sig=0 instead of inverting.
  - DIE therefore lasts exactly FLASH_TOGGLES*FLASH_HALF cycles.
  - Flash pattern starts with 1 and alternates.
  - Hits, keys and Body_add_sig are ignored.
- END:
  - Hold counter runs 0..END_HOLD-1. At terminal count -> START, counter cleared.
  - Keys are ignored. Score holds.
- Flash_sig is 0 in every state except DIE.
- Score holds through END and START until the next START -> PLAY transition.
- Counter widths: sized by $clog2 of each parameter. No counter runs outside its own state; each clears on leaving its state.
- Reset asserted mid-DIE or mid-END: returns to START immediately. Score clears to 00.
- Illegal state encodings recover to START on the next clock.

Test Plan:
All scenarios use FLASH_HALF=4, FLASH_TOGGLES=4, END_HOLD=10.
1. Rst_n low with Key_up held, release Rst_n, keep Key_up high for 20 cycles -> Game_status stays 3'b001. Drop then raise Key_up -> Game_status=3'b010 one cycle after the rise, Score_bcd=8'h00.
2. In PLAY, pulse Body_add_sig 12 times (each high 2 cycles) -> Score_bcd=8'h12. Hold Body_add_sig high 5 cycles -> only +1 (8'h13).
3. Preload 99 via 99 pulses, send one more pulse -> Score_bcd=8'h00.
4. In PLAY, assert Hit_wall_sig 1 cycle -> next cycle Game_status=3'b011 with Flash_sig=1.
   - Flash_sig sequence in 4-cycle runs: 1,0,1,0 (16 cycles).
   - Then Game_status=3'b100, Flash_sig=0.
   - After 10 more cycles Game_status=3'b001. Score unchanged throughout.
5. Same cycle as Hit_body_sig=1, raise Body_add_sig with score 8'h05 -> Score_bcd=8'h06 and Game_status=3'b011.
   - Hit_wall_sig pulses during DIE/END and keys during DIE/END -> no effect.
6. Assert Rst_n low at DIE cycle 7 -> Game_status=3'b001, Flash_sig=0, Score_bcd=8'h00 immediately (asynchronously).
